pipeline_hazard_ctrl: RTL and testbench

Hazard and bypass controller sitting beside the execute stage of the 5-stage pipeline. It tracks the instructions occupying D/X, X/M and M/W, and drives the execute stage's `mx_bypass_A/B` and `wx_bypass_A/B` selects. It also produces the stall, bubble and flush controls for fetch/decode on load-use hazards, taken control transfers and multicycle mul/div. It consumes execute's `j_took_branch` and `write_exception`.

---
 rtl/pipeline_pkg.sv | 44 ++++
 rtl/insn_reg_decode.sv | 62 ++++++
 rtl/pipeline_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage pipeline: opcodes, ALU ops, field positions
// and the architectural registers with special roles.
package pipeline_pkg;

    localparam int INSN_W = 32;
    localparam int REG_W  = 5;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    typedef enum logic [4:0] {
        OP_R    = 5'b00000,
        OP_J    = 5'b00001,
        OP_BNE  = 5'b00010,
        OP_JAL  = 5'b00011,
        OP_JR   = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_BLT  = 5'b00110,
        OP_SW   = 5'b00111,
        OP_LW   = 5'b01000,
        OP_SETX = 5'b10101,
        OP_BEX  = 5'b10110
    } opcode_e;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [REG_W-1:0] RSTATUS = 5'd30;
    localparam logic [REG_W-1:0] RA      = 5'd31;

    function automatic logic is_multdiv(input logic [INSN_W-1:0] insn);
        return (insn[OP_HI:OP_LO] == OP_R) &&
               ((insn[ALU_HI:ALU_LO] == ALU_MUL) || (insn[ALU_HI:ALU_LO] == ALU_DIV));
    endfunction

endpackage

// File: rtl/insn_reg_decode.sv
// Register-usage decode of one tracked instruction: which registers it reads
// on operands A/B and which one it writes. Register $0 is never reported valid.
module insn_reg_decode
    import pipeline_pkg::*;
(
    input  logic [INSN_W-1:0] insn_i,
    input  logic              exc_i,
    output logic [REG_W-1:0]  src_a_o,
    output logic [REG_W-1:0]  src_b_o,
    output logic [REG_W-1:0]  dest_o,
    output logic              src_a_vld_o,
    output logic              src_b_vld_o,
    output logic              dest_vld_o
);

    logic [4:0]       op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             unused_bits;

    assign op          = insn_i[OP_HI:OP_LO];
    assign rd          = insn_i[RD_HI:RD_LO];
    assign rs          = insn_i[RS_HI:RS_LO];
    assign rt          = insn_i[RT_HI:RT_LO];
    assign unused_bits = ^insn_i[RT_LO-1:0];

    always_comb begin
        src_a_o = '0;
        src_b_o = '0;
        dest_o  = '0;
        case (op)
            OP_R: begin
                src_a_o = rs;
                src_b_o = rt;
                dest_o  = rd;
            end
            OP_ADDI, OP_LW: begin
                src_a_o = rs;
                dest_o  = rd;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a_o = rs;
                src_b_o = rd;
            end
            OP_JR:   src_b_o = rd;
            OP_BEX:  src_a_o = RSTATUS;
            OP_JAL:  dest_o  = RA;
            OP_SETX: dest_o  = RSTATUS;
            default: ;
        endcase
        // An excepting instruction writes rstatus in place of its own rd.
        if (exc_i) begin
            dest_o = RSTATUS;
        end
    end

    assign src_a_vld_o = (src_a_o != '0);
    assign src_b_vld_o = (src_b_o != '0);
    assign dest_vld_o  = (dest_o  != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/bypass controller beside execute: tracks D/X, X/M, M/W and produces
// bypass selects plus stall/bubble/flush for load-use, branches and mul/div.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULTDIV_CYCLES = 33
)
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [INSN_W-1:0] fd_insn,
    input  logic              j_took_branch,
    input  logic              write_exception,
    output logic [INSN_W-1:0] dx_insn_out,
    output logic              mx_bypass_A,
    output logic              mx_bypass_B,
    output logic              wx_bypass_A,
    output logic              wx_bypass_B,
    output logic              wm_bypass,
    output logic              stall_fd,
    output logic              bubble_dx,
    output logic              flush_fd,
    output logic              stall_dx
);

    localparam logic [5:0] MD_LOAD = 6'(MULTDIV_CYCLES - 1);

    logic [INSN_W-1:0] dx_insn_q, dx_insn_d;
    logic [INSN_W-1:0] xm_insn_q, xm_insn_d;
    logic [INSN_W-1:0] mw_insn_q, mw_insn_d;
    logic              xm_exc_q, xm_exc_d;
    logic              mw_exc_q, mw_exc_d;
    logic [5:0]        md_cnt_q, md_cnt_d;

    logic [REG_W-1:0] fd_src_a, fd_src_b, fd_dest;
    logic             fd_src_a_vld, fd_src_b_vld, fd_dest_vld;
    logic [REG_W-1:0] dx_src_a, dx_src_b, dx_dest;
    logic             dx_src_a_vld, dx_src_b_vld, dx_dest_vld;
    logic [REG_W-1:0] xm_src_a, xm_src_b, xm_dest;
    logic             xm_src_a_vld, xm_src_b_vld, xm_dest_vld;
    logic [REG_W-1:0] mw_src_a, mw_src_b, mw_dest;
    logic             mw_src_a_vld, mw_src_b_vld, mw_dest_vld;
    logic             unused_dec;

    insn_reg_decode u_dec_fd (
        .insn_i(fd_insn), .exc_i(1'b0),
        .src_a_o(fd_src_a), .src_b_o(fd_src_b), .dest_o(fd_dest),
        .src_a_vld_o(fd_src_a_vld), .src_b_vld_o(fd_src_b_vld), .dest_vld_o(fd_dest_vld)
    );

    insn_reg_decode u_dec_dx (
        .insn_i(dx_insn_q), .exc_i(1'b0),
        .src_a_o(dx_src_a), .src_b_o(dx_src_b), .dest_o(dx_dest),
        .src_a_vld_o(dx_src_a_vld), .src_b_vld_o(dx_src_b_vld), .dest_vld_o(dx_dest_vld)
    );

    insn_reg_decode u_dec_xm (
        .insn_i(xm_insn_q), .exc_i(xm_exc_q),
        .src_a_o(xm_src_a), .src_b_o(xm_src_b), .dest_o(xm_dest),
        .src_a_vld_o(xm_src_a_vld), .src_b_vld_o(xm_src_b_vld), .dest_vld_o(xm_dest_vld)
    );

    insn_reg_decode u_dec_mw (
        .insn_i(mw_insn_q), .exc_i(mw_exc_q),
        .src_a_o(mw_src_a), .src_b_o(mw_src_b), .dest_o(mw_dest),
        .src_a_vld_o(mw_src_a_vld), .src_b_vld_o(mw_src_b_vld), .dest_vld_o(mw_dest_vld)
    );

    assign unused_dec = ^{fd_dest, fd_dest_vld, xm_src_a, xm_src_b, xm_src_a_vld,
                          xm_src_b_vld, mw_src_a, mw_src_b, mw_src_a_vld, mw_src_b_vld};

    logic load_use;
    logic flush;

    assign stall_dx = (md_cnt_q != '0);

    assign load_use = (dx_insn_q[OP_HI:OP_LO] == OP_LW) && dx_dest_vld &&
                      ((fd_src_a_vld && (fd_src_a == dx_dest)) ||
                       (fd_src_b_vld && (fd_src_b == dx_dest)));

    // Gated by reset_n so the flush path also reads 0 while reset is held.
    assign flush     = reset_n && j_took_branch && !stall_dx;
    assign flush_fd  = flush;
    assign stall_fd  = stall_dx || (load_use && !flush);
    assign bubble_dx = !stall_dx && (flush || load_use);

    assign mx_bypass_A = dx_src_a_vld && xm_dest_vld && (dx_src_a == xm_dest);
    assign mx_bypass_B = dx_src_b_vld && xm_dest_vld && (dx_src_b == xm_dest);
    assign wx_bypass_A = dx_src_a_vld && mw_dest_vld && (dx_src_a == mw_dest) && !mx_bypass_A;
    assign wx_bypass_B = dx_src_b_vld && mw_dest_vld && (dx_src_b == mw_dest) && !mx_bypass_B;
    assign wm_bypass   = (xm_insn_q[OP_HI:OP_LO] == OP_SW) && mw_dest_vld &&
                         (xm_insn_q[RD_HI:RD_LO] == mw_dest);

    assign dx_insn_out = dx_insn_q;

    always_comb begin
        mw_insn_d = xm_insn_q;
        mw_exc_d  = xm_exc_q;
        xm_insn_d = stall_dx ? '0   : dx_insn_q;
        xm_exc_d  = stall_dx ? 1'b0 : write_exception;
        dx_insn_d = fd_insn;
        md_cnt_d  = '0;
        if (stall_dx) begin
            dx_insn_d = dx_insn_q;
            md_cnt_d  = md_cnt_q - 6'd1;
        end else if (bubble_dx) begin
            dx_insn_d = '0;
        end else if (is_multdiv(fd_insn)) begin
            md_cnt_d  = MD_LOAD;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dx_insn_q <= '0;
            xm_insn_q <= '0;
            mw_insn_q <= '0;
            xm_exc_q  <= 1'b0;
            mw_exc_q  <= 1'b0;
            md_cnt_q  <= '0;
        end else begin
            dx_insn_q <= dx_insn_d;
            xm_insn_q <= xm_insn_d;
            mw_insn_q <= mw_insn_d;
            xm_exc_q  <= xm_exc_d;
            mw_exc_q  <= mw_exc_d;
            md_cnt_q  <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with MULTDIV_CYCLES=4: each cycle's
// expected D/X word and control flags are queued at drive time and checked mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] MXA  = 9'h100;
    localparam logic [8:0] MXB  = 9'h080;
    localparam logic [8:0] WXA  = 9'h040;
    localparam logic [8:0] WXB  = 9'h020;
    localparam logic [8:0] WM   = 9'h010;
    localparam logic [8:0] SFD  = 9'h008;
    localparam logic [8:0] BDX  = 9'h004;
    localparam logic [8:0] FFD  = 9'h002;
    localparam logic [8:0] SDX  = 9'h001;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] fd_insn = '0;
    logic        j_took_branch = 1'b0;
    logic        write_exception = 1'b0;
    logic [31:0] dx_insn_out;
    logic        mx_bypass_A, mx_bypass_B, wx_bypass_A, wx_bypass_B, wm_bypass;
    logic        stall_fd, bubble_dx, flush_fd, stall_dx;

    int n_cmp = 0;
    int n_err = 0;
    string       tag_q[$];
    logic [40:0] exp_q[$];

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MULTDIV_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .fd_insn(fd_insn),
        .j_took_branch(j_took_branch), .write_exception(write_exception),
        .dx_insn_out(dx_insn_out),
        .mx_bypass_A(mx_bypass_A), .mx_bypass_B(mx_bypass_B),
        .wx_bypass_A(wx_bypass_A), .wx_bypass_B(wx_bypass_B),
        .wm_bypass(wm_bypass), .stall_fd(stall_fd), .bubble_dx(bubble_dx),
        .flush_fd(flush_fd), .stall_dx(stall_dx)
    );

    wire [40:0] obs = {dx_insn_out, mx_bypass_A, mx_bypass_B, wx_bypass_A, wx_bypass_B,
                       wm_bypass, stall_fd, bubble_dx, flush_fd, stall_dx};

    task automatic check_eq(input string tag, input logic [40:0] got, input logic [40:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pop_compare();
        string       t;
        logic [40:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, obs, e);
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] exp_dx, input logic [8:0] exp_f);
        tag_q.push_back(tag);
        exp_q.push_back({exp_dx, exp_f});
        #1;
        pop_compare();
    endtask

    task automatic step(input string tag, input logic [31:0] fd, input logic j, input logic exc,
                        input logic [31:0] exp_dx, input logic [8:0] exp_f);
        @(negedge clock);
        fd_insn         = fd;
        j_took_branch   = j;
        write_exception = exc;
        expect_now(tag, exp_dx, exp_f);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3; i++) step(tag, 32'd0, 1'b0, 1'b0, 32'd0, NONE);
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] i1, i2, i3, l4, a5, x6, y7, l8, a9, e10, bx, ad11, sw11, mu, d13, dv;
        i1   = itype(5'b00101, 5'd1, 5'd0, 17'd5);
        i2   = rtype(5'd2, 5'd1, 5'd1, 5'd0);
        i3   = rtype(5'd3, 5'd1, 5'd2, 5'd0);
        l4   = itype(5'b01000, 5'd4, 5'd0, 17'd0);
        a5   = rtype(5'd5, 5'd4, 5'd0, 5'd0);
        x6   = rtype(5'd6, 5'd0, 5'd0, 5'd0);
        y7   = rtype(5'd7, 5'd6, 5'd6, 5'd0);
        l8   = itype(5'b01000, 5'd8, 5'd0, 17'd0);
        a9   = rtype(5'd9, 5'd8, 5'd0, 5'd0);
        e10  = rtype(5'd10, 5'd1, 5'd2, 5'd0);
        bx   = {5'b10110, 27'd100};
        ad11 = itype(5'b00101, 5'd11, 5'd0, 17'd1);
        sw11 = itype(5'b00111, 5'd11, 5'd0, 17'd0);
        mu   = rtype(5'd12, 5'd1, 5'd2, 5'b00110);
        d13  = rtype(5'd13, 5'd12, 5'd0, 5'd0);
        dv   = rtype(5'd14, 5'd3, 5'd4, 5'b00111);

        // Reset held with hostile inputs: every output must read 0.
        fd_insn = l4;
        j_took_branch = 1'b1;
        #2;
        expect_now("reset_outputs", 32'd0, NONE);
        @(negedge clock);
        reset_n = 1'b1;
        j_took_branch = 1'b0;
        fd_insn = '0;

        step("byp_c0", i1, 0, 0, 32'd0, NONE);
        step("byp_c1", i2, 0, 0, i1, NONE);
        step("byp_mx_ab", i3, 0, 0, i2, MXA | MXB);
        step("byp_wx_a_mx_b", 32'd0, 0, 0, i3, WXA | MXB);
        drain("byp_drain");

        step("lu_c0", l4, 0, 0, 32'd0, NONE);
        step("lu_stall", a5, 0, 0, l4, SFD | BDX);
        step("lu_bubble_out", a5, 0, 0, 32'd0, NONE);
        step("lu_wx_a", 32'd0, 0, 0, a5, WXA);
        drain("lu_drain");

        step("br_c0", x6, 0, 0, 32'd0, NONE);
        step("br_flush", y7, 1, 0, x6, FFD | BDX);
        drain("br_nop_dx");

        step("brlu_c0", l8, 0, 0, 32'd0, NONE);
        step("brlu_flush_wins", a9, 1, 0, l8, FFD | BDX);
        drain("brlu_drain");

        step("exc_c0", e10, 0, 0, 32'd0, NONE);
        step("exc_c1", bx, 0, 1, e10, NONE);
        step("exc_bex_mx_a", 32'd0, 0, 0, bx, MXA);
        drain("exc_drain");

        step("wm_c0", ad11, 0, 0, 32'd0, NONE);
        step("wm_c1", sw11, 0, 0, ad11, NONE);
        step("wm_sw_mx_b", 32'd0, 0, 0, sw11, MXB);
        step("wm_bypass", 32'd0, 0, 0, 32'd0, WM);
        drain("wm_drain");

        step("md_c0", i1, 0, 0, 32'd0, NONE);
        step("md_c1", mu, 0, 0, i1, NONE);
        step("md_stall1_br_ignored", d13, 1, 0, mu, SDX | SFD | MXA);
        step("md_stall2", d13, 0, 0, mu, SDX | SFD | WXA);
        step("md_stall3", d13, 0, 0, mu, SDX | SFD);
        step("md_release", d13, 0, 0, mu, NONE);
        step("md_dep_mx_a", 32'd0, 0, 0, d13, MXA);
        drain("md_drain");

        step("rst_c0", dv, 0, 0, 32'd0, NONE);
        step("rst_stall", d13, 0, 0, dv, SDX | SFD);
        #2;
        reset_n = 1'b0;
        j_took_branch = 1'b1;
        fd_insn = l4;
        expect_now("rst_async_outputs", 32'd0, NONE);
        check_eq("rst_md_cnt", {35'd0, dut.md_cnt_q}, 41'd0);
        check_eq("rst_xm_insn", {9'd0, dut.xm_insn_q}, 41'd0);
        check_eq("rst_mw_insn", {9'd0, dut.mw_insn_q}, 41'd0);
        @(negedge clock);
        reset_n = 1'b1;
        j_took_branch = 1'b0;
        fd_insn = '0;
        step("rst_after", 32'd0, 0, 0, 32'd0, NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
